// File: rtl/addsub_accumulator_pkg.sv
// Shared definitions for the add/subtract accumulator: opcodes, FSM states and
// the default datapath width.
package addsub_accumulator_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_core.sv
// Ripple-carry adder/subtractor. When m=1, b is inverted and m is the carry-in,
// so the result is a - b in two's complement.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_bx;

  assign w_carry[0] = m;

  // One full-adder cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_bx[i]      = b[i] ^ m;
    assign sum[i]       = a[i] ^ w_bx[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_bx[i]) | (w_carry[i] & (a[i] ^ w_bx[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator sequencing the ripple adder/subtractor with valid/ready handshakes
// on the command and result sides.
//   state | meaning
//   IDLE  | ready for a command; in_ready=1
//   EXEC  | adder evaluates acc op operand; acc/flags captured at end of cycle
//   RESP  | result and flags presented until the consumer takes them
module addsub_accumulator
  import addsub_accumulator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v,
  output logic [WIDTH-1:0] acc
);

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  state_e           w_state_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_c, r_z, r_n, r_v;

  logic             w_mode;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_result;
  logic             w_c;
  logic             w_v;

  assign w_mode = (r_op == OP_SUB);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (r_acc),
    .b    (r_operand),
    .m    (w_mode),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Carry and overflow only carry meaning for the arithmetic opcodes.
  always_comb begin
    w_result = w_sum;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (r_op)
      OP_LOAD: w_result = r_operand;
      OP_CLR:  w_result = '0;
      OP_ADD: begin
        w_c = w_cout;
        w_v = (r_acc[MSB] == r_operand[MSB]) && (w_sum[MSB] != r_acc[MSB]);
      end
      OP_SUB: begin
        w_c = w_cout;
        w_v = (r_acc[MSB] != r_operand[MSB]) && (w_sum[MSB] != r_acc[MSB]);
      end
      default: w_result = w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LOAD;
      r_operand <= '0;
      r_acc     <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_v       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && in_valid) begin
        r_op      <= op_e'(in_op);
        r_operand <= in_data;
      end
      if (r_state == ST_EXEC) begin
        r_acc <= w_result;
        r_c   <= w_c;
        r_z   <= (w_result == '0);
        r_n   <= w_result[MSB];
        r_v   <= w_v;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_RESP);
  assign out_data  = r_acc;
  assign out_c     = r_c;
  assign out_z     = r_z;
  assign out_n     = r_n;
  assign out_v     = r_v;
  assign acc       = r_acc;

endmodule
